// File: rtl/sap_loader_pkg.sv
// Shared types and widths for the SAP RAM program loader.
package sap_loader_pkg;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GET_B0  = 3'd1,
    GET_B1  = 3'd2,
    SET_MAR = 3'd3,
    WR_RAM  = 3'd4,
    GET_CHK = 3'd5,
    FIN     = 3'd6
  } state_e;
endpackage

// File: rtl/sap_loader_if.sv
// Byte-stream input and shared-bus write signals of the SAP loader.
interface sap_loader_if;
  import sap_loader_pkg::*;

  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              bus_drive;
  logic [WORD_W-1:0] bus_out;
  logic              mar_write;
  logic              ram_write;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, bus_drive, bus_out, mar_write, ram_write
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, bus_drive, bus_out, mar_write, ram_write
  );
endinterface

// File: rtl/sap_loader_pack.sv
// Packs two consecutive bytes into a 16-bit word; HI_FIRST selects which half arrives first.
module sap_loader_pack
  import sap_loader_pkg::*;
#(
  parameter bit HI_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] i_byte,
  input  logic              i_load_b0,
  input  logic              i_load_b1,
  output logic [WORD_W-1:0] o_word
);
  logic [BYTE_W-1:0] r_hi;
  logic [BYTE_W-1:0] r_lo;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (i_load_b0) begin
        if (HI_FIRST) r_hi <= i_byte;
        else          r_lo <= i_byte;
      end
      if (i_load_b1) begin
        if (HI_FIRST) r_lo <= i_byte;
        else          r_hi <= i_byte;
      end
    end
  end

  assign o_word = {r_hi, r_lo};
endmodule

// File: rtl/sap_loader.sv
// SAP program loader: streams byte pairs into RAM via MAR-then-RAM bus writes while holding the CPU.
// Optional trailing checksum byte enabled by defining SAP_LOADER_CHECKSUM_EN.
module sap_loader
  import sap_loader_pkg::*;
#(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned HI_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W-1:0] i_word_count,
  sap_loader_if.master      bus,
  output logic              o_cpu_hold,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_chk_err
);
  state_e            r_state;
  state_e            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_remaining;
  logic [WORD_W-1:0] w_word;
  logic              w_load_b0;
  logic              w_load_b1;
  logic              w_accept;
  logic              w_last;
`ifdef SAP_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] r_sum;
  logic              r_chk_err;
  logic              w_chk_take;
`endif

  assign w_accept = (r_state == IDLE) && i_start;
  assign w_last   = (r_remaining == ADDR_W'(1));

  sap_loader_pack #(
    .HI_FIRST (HI_FIRST != 0)
  ) u_pack (
    .clk       (clk),
    .rst       (rst),
    .i_byte    (bus.rx_data),
    .i_load_b0 (w_load_b0),
    .i_load_b1 (w_load_b1),
    .o_word    (w_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr      <= i_base_addr;
        r_remaining <= i_word_count;
      end
      if (r_state == WR_RAM) begin
        r_addr      <= r_addr + ADDR_W'(1);
        r_remaining <= r_remaining - ADDR_W'(1);
      end
    end
  end

  // Handshake is decoded from rx_valid directly so rx_ready stays a pure state decode.
  always_comb begin
    w_next        = r_state;
    bus.rx_ready  = 1'b0;
    bus.bus_drive = 1'b0;
    bus.bus_out   = '0;
    bus.mar_write = 1'b0;
    bus.ram_write = 1'b0;
    w_load_b0     = 1'b0;
    w_load_b1     = 1'b0;
    o_done        = 1'b0;
`ifdef SAP_LOADER_CHECKSUM_EN
    w_chk_take    = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (i_start) w_next = (i_word_count == '0) ? FIN : GET_B0;
      end
      GET_B0: begin
        bus.rx_ready = 1'b1;
        if (bus.rx_valid) begin
          w_load_b0 = 1'b1;
          w_next    = GET_B1;
        end
      end
      GET_B1: begin
        bus.rx_ready = 1'b1;
        if (bus.rx_valid) begin
          w_load_b1 = 1'b1;
          w_next    = SET_MAR;
        end
      end
      SET_MAR: begin
        bus.bus_drive = 1'b1;
        bus.bus_out   = WORD_W'(r_addr);
        bus.mar_write = 1'b1;
        w_next        = WR_RAM;
      end
      WR_RAM: begin
        bus.bus_drive = 1'b1;
        bus.bus_out   = w_word;
        bus.ram_write = 1'b1;
`ifdef SAP_LOADER_CHECKSUM_EN
        w_next        = w_last ? GET_CHK : GET_B0;
`else
        w_next        = w_last ? FIN : GET_B0;
`endif
      end
`ifdef SAP_LOADER_CHECKSUM_EN
      GET_CHK: begin
        bus.rx_ready = 1'b1;
        if (bus.rx_valid) begin
          w_chk_take = 1'b1;
          w_next     = FIN;
        end
      end
`endif
      FIN: begin
        o_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign o_busy     = (r_state != IDLE);
  assign o_cpu_hold = (r_state != IDLE);

`ifdef SAP_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum     <= '0;
      r_chk_err <= 1'b0;
    end else if (w_accept) begin
      r_sum     <= '0;
      r_chk_err <= 1'b0;
    end else begin
      if (w_load_b0 || w_load_b1) r_sum <= r_sum + bus.rx_data;
      if (w_chk_take) r_chk_err <= (BYTE_W'(r_sum + bus.rx_data) != '0);
    end
  end

  assign o_chk_err = r_chk_err;
`else
  assign o_chk_err = 1'b0;
`endif
endmodule

// File: tb/tb_sap_loader.sv
// Directed self-checking bench for sap_loader (HI_FIRST=1 and HI_FIRST=0 instances).
module tb_sap_loader;
`ifdef SAP_LOADER_CHECKSUM_EN
  localparam int XC = 1;
`else
  localparam int XC = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start0 = 1'b0;
  logic        start1 = 1'b0;
  logic [15:0] base   = '0;
  logic [15:0] cnt    = '0;
  logic [7:0]  rx_data  = '0;
  logic        rx_valid = 1'b0;
  logic        hold0, busy0, done0, chk0;
  logic        hold1, busy1, done1, chk1;

  sap_loader_if if0 ();
  sap_loader_if if1 ();

  assign if0.rx_data  = rx_data;
  assign if0.rx_valid = rx_valid;
  assign if1.rx_data  = rx_data;
  assign if1.rx_valid = rx_valid;

  sap_loader #(.ADDR_W(16), .HI_FIRST(1)) u_dut0 (
    .clk(clk), .rst(rst), .i_start(start0), .i_base_addr(base), .i_word_count(cnt),
    .bus(if0), .o_cpu_hold(hold0), .o_busy(busy0), .o_done(done0), .o_chk_err(chk0)
  );

  sap_loader #(.ADDR_W(16), .HI_FIRST(0)) u_dut1 (
    .clk(clk), .rst(rst), .i_start(start1), .i_base_addr(base), .i_word_count(cnt),
    .bus(if1), .o_cpu_hold(hold1), .o_busy(busy1), .o_done(done1), .o_chk_err(chk1)
  );

  bit          sel = 1'b0;
  logic        s_ready, s_drive, s_mar, s_ram, s_hold, s_busy, s_done, s_chk;
  logic [15:0] s_bus;
  assign s_ready = sel ? if1.rx_ready  : if0.rx_ready;
  assign s_drive = sel ? if1.bus_drive : if0.bus_drive;
  assign s_mar   = sel ? if1.mar_write : if0.mar_write;
  assign s_ram   = sel ? if1.ram_write : if0.ram_write;
  assign s_bus   = sel ? if1.bus_out   : if0.bus_out;
  assign s_hold  = sel ? hold1 : hold0;
  assign s_busy  = sel ? busy1 : busy0;
  assign s_done  = sel ? done1 : done0;
  assign s_chk   = sel ? chk1  : chk0;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  tx[$];
  logic [15:0] mar_log[$];
  logic [15:0] ram_log[$];
  int   done_cyc, ready_cyc, first_strobe, taken, hold_viol, drive_viol, overlap;
  logic done_chk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic add_chk();
`ifdef SAP_LOADER_CHECKSUM_EN
    logic [7:0] s;
    s = 8'h00;
    foreach (tx[i]) s = s + tx[i];
    tx.push_back(8'h00 - s);
`endif
  endtask

  // Starts a load, feeds tx[] whenever rx_valid (every gap cycles) meets rx_ready,
  // logs bus strobes, and stops at done or after a cycle budget.
  task automatic do_load(input bit s, input logic [15:0] b, input logic [15:0] n,
                         input int gap, input int mid_a, input int mid_b);
    int idx;
    idx = 0;
    sel = s; base = b; cnt = n; rx_valid = 1'b0; rx_data = 8'h00;
    mar_log.delete(); ram_log.delete();
    done_cyc = -1; ready_cyc = 0; first_strobe = -1; taken = 0;
    hold_viol = 0; drive_viol = 0; overlap = 0; done_chk = 1'bx;
    if (s) start1 = 1'b1; else start0 = 1'b1;
    tick();
    for (int c = 1; c <= 300; c++) begin
      start0 = 1'b0; start1 = 1'b0;
      if (c == mid_a || c == mid_b) begin
        base = 16'h0500; cnt = 16'h0005;
        if (s) start1 = 1'b1; else start0 = 1'b1;
      end
      if (!s_hold || !s_busy) hold_viol++;
      if ((s_drive !== (s_mar | s_ram)) || (!s_drive && s_bus != 16'h0000)) drive_viol++;
      if (s_mar && s_ram) overlap++;
      if ((s_mar || s_ram) && first_strobe < 0) first_strobe = c;
      if (s_mar) mar_log.push_back(s_bus);
      if (s_ram) ram_log.push_back(s_bus);
      if (s_ready) ready_cyc++;
      if (s_done) begin
        done_cyc = c;
        done_chk = s_chk;
        break;
      end
      rx_valid = ((c % gap) == 0) && (idx < tx.size());
      rx_data  = rx_valid ? tx[idx] : 8'h00;
      if (rx_valid && s_ready) begin
        idx++;
        taken++;
      end
      tick();
    end
    start0 = 1'b0; start1 = 1'b0; rx_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    tick(); tick();
    sel = 1'b0;
    chk("reset_outs0", {s_ready, s_drive, s_mar, s_ram, s_hold, s_busy, s_done, s_chk, s_bus}, 32'h0);
    sel = 1'b1;
    chk("reset_outs1", {s_ready, s_drive, s_mar, s_ram, s_hold, s_busy, s_done, s_chk, s_bus}, 32'h0);
    rst = 1'b0;
    tick();

    // Two-word load, rx_valid held high
    tx = '{8'h12, 8'h34, 8'hAB, 8'hCD}; add_chk();
    do_load(1'b0, 16'h0010, 16'd2, 1, 0, 0);
    chk("t1_done_cyc", done_cyc, 9 + XC);
    chk("t1_mar_n", mar_log.size(), 2);
    chk("t1_mar0", mar_log[0], 16'h0010);
    chk("t1_mar1", mar_log[1], 16'h0011);
    chk("t1_ram_n", ram_log.size(), 2);
    chk("t1_ram0", ram_log[0], 16'h1234);
    chk("t1_ram1", ram_log[1], 16'hABCD);
    chk("t1_hold", hold_viol, 0);
    chk("t1_drive", drive_viol, 0);
    chk("t1_overlap", overlap, 0);
    chk("t1_chk_err", done_chk, 1'b0);
    tick();
    chk("t1_idle_after", {s_busy, s_hold, s_done}, 3'b000);

    // Stalled handshake: rx_valid one cycle in three
    tx = '{8'h5A, 8'hC3}; add_chk();
    do_load(1'b0, 16'h0040, 16'd1, 3, 0, 0);
    chk("t2_done_cyc", done_cyc, 9 + XC);
    chk("t2_first_strobe", first_strobe, 7);
    chk("t2_ready_cyc", ready_cyc, 6 + XC);
    chk("t2_taken", taken, 2 + XC);
    chk("t2_mar0", mar_log[0], 16'h0040);
    chk("t2_ram_n", ram_log.size(), 1);
    chk("t2_ram0", ram_log[0], 16'h5AC3);
    chk("t2_drive", drive_viol, 0);
    tick();

    // Zero word count
    tx.delete();
    do_load(1'b0, 16'h1234, 16'd0, 1, 0, 0);
    chk("t3_done_cyc", done_cyc, 1);
    chk("t3_strobes", mar_log.size() + ram_log.size(), 0);
    chk("t3_ready_cyc", ready_cyc, 0);
    tick();
    chk("t3_idle_after", {s_busy, s_done}, 2'b00);

    // Address wrap, HI_FIRST=1
    tx = '{8'h11, 8'h22, 8'h33, 8'h44}; add_chk();
    do_load(1'b0, 16'hFFFF, 16'd2, 1, 0, 0);
    chk("t4_done_cyc", done_cyc, 9 + XC);
    chk("t4_mar0", mar_log[0], 16'hFFFF);
    chk("t4_mar1", mar_log[1], 16'h0000);
    chk("t4_ram1", ram_log[1], 16'h3344);
    tick();

    // Address wrap, HI_FIRST=0
    tx = '{8'h34, 8'h12, 8'h78, 8'h56}; add_chk();
    do_load(1'b1, 16'hFFFF, 16'd2, 1, 0, 0);
    chk("t5_done_cyc", done_cyc, 9 + XC);
    chk("t5_mar1", mar_log[1], 16'h0000);
    chk("t5_ram0", ram_log[0], 16'h1234);
    chk("t5_ram1", ram_log[1], 16'h5678);
    chk("t5_hold", hold_viol, 0);
    tick();

    // Reset during GET_B1 of the first word
    sel = 1'b0; base = 16'h0200; cnt = 16'd2;
    start0 = 1'b1; rx_valid = 1'b1; rx_data = 8'hAA;
    tick();
    start0 = 1'b0;
    tick();
    chk("t6_in_b1_ready", s_ready, 1'b1);
    rst = 1'b1; rx_valid = 1'b0;
    tick();
    chk("t6_rst_outs", {s_ready, s_drive, s_mar, s_ram, s_hold, s_busy, s_done, s_chk, s_bus}, 32'h0);
    rst = 1'b0;
    tick();
    chk("t6_idle", s_busy, 1'b0);

    // Clean load after reset; start pulses mid-load are ignored
    tx = '{8'hBE, 8'hEF}; add_chk();
    do_load(1'b0, 16'h0300, 16'd1, 1, 2, 4);
    chk("t7_done_cyc", done_cyc, 5 + XC);
    chk("t7_mar_n", mar_log.size(), 1);
    chk("t7_mar0", mar_log[0], 16'h0300);
    chk("t7_ram0", ram_log[0], 16'hBEEF);
    tick();
    chk("t7_idle_after", s_busy, 1'b0);

`ifdef SAP_LOADER_CHECKSUM_EN
    // Checksum: good trailer, bad trailer, then cleared by next start
    tx = '{8'h01, 8'h02, 8'hFD};
    do_load(1'b0, 16'h0080, 16'd1, 1, 0, 0);
    chk("t8_done_cyc", done_cyc, 6);
    chk("t8_ram0", ram_log[0], 16'h0102);
    chk("t8_chk_ok", done_chk, 1'b0);
    tick();
    tx = '{8'h01, 8'h02, 8'hFE};
    do_load(1'b0, 16'h0080, 16'd1, 1, 0, 0);
    chk("t8_chk_bad", done_chk, 1'b1);
    tick();
    chk("t8_chk_sticky", s_chk, 1'b1);
    tx.delete();
    do_load(1'b0, 16'h0000, 16'd0, 1, 0, 0);
    chk("t8_chk_cleared", done_chk, 1'b0);
    tick();
`else
    chk("t8_chk_tied", chk0 | chk1, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
